// File: rtl/adder_burst_accum.sv
// Burst accumulator behind the adder datapath: sums each valid/ready burst (closed by in_last
// or MAX_BEATS) and presents total, beat count and overflow. Optional: ADDER_BURST_ACCUM_SAT_EN.
module adder_burst_accum #(
    parameter  int WIDTH     = 32,
    parameter  int MAX_BEATS = 256,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf,
    output logic             out_trunc
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] count_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] out_sum_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_ovf_reg;
    logic             out_trunc_reg;
    logic             out_valid_reg;

    logic             accept;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] count_next;
    logic             ovf_next;
    logic             hit_max;

    assign in_ready  = (state_reg != DONE);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign out_sum   = out_sum_reg;
    assign out_count = out_count_reg;
    assign out_ovf   = out_ovf_reg;
    assign out_trunc = out_trunc_reg;

    assign add_full = {1'b0, acc_reg} + {1'b0, in_data};

`ifdef ADDER_BURST_ACCUM_SAT_EN
    // Once clamped, every later nonzero add carries again, so acc stays all-ones.
    assign add_sum = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
`else
    assign add_sum = add_full[WIDTH-1:0];
`endif

    // The first beat of a burst loads rather than adds.
    always_comb begin
        acc_next   = add_sum;
        count_next = count_reg + CNT_W'(1);
        ovf_next   = ovf_reg | add_full[WIDTH];
        if (state_reg == IDLE) begin
            acc_next   = in_data;
            count_next = CNT_W'(1);
            ovf_next   = 1'b0;
        end
        hit_max = (count_next == CNT_W'(MAX_BEATS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            out_sum_reg   <= '0;
            out_count_reg <= '0;
            out_ovf_reg   <= 1'b0;
            out_trunc_reg <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACC: begin
                    if (accept) begin
                        acc_reg   <= acc_next;
                        count_reg <= count_next;
                        ovf_reg   <= ovf_next;
                        if (in_last || hit_max) begin
                            state_reg     <= DONE;
                            out_sum_reg   <= acc_next;
                            out_count_reg <= count_next;
                            out_ovf_reg   <= ovf_next;
                            out_trunc_reg <= !in_last;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_burst_accum.sv
// Bench for adder_burst_accum (MAX_BEATS=4): table of bursts plus hand-written corner sequences,
// results checked against a queue of expected outputs.
module tb_adder_burst_accum;

    localparam int WIDTH     = 32;
    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
`ifdef ADDER_BURST_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    logic             out_trunc;

    adder_burst_accum #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_count(out_count), .out_ovf(out_ovf), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             ovf;
        logic             trunc;
    } res_t;

    typedef struct {
        logic [3:0][WIDTH-1:0] d;
        int                    n;
        logic [WIDTH-1:0]      sum;
        logic [CNT_W-1:0]      cnt;
        logic                  ovf;
    } vec_t;

    res_t exp_q[$];
    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Drives one beat from posedge+1 and returns at posedge+1 after it was accepted.
    task automatic beat(input logic [WIDTH-1:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        sync();
        in_valid = 1'b0;
        in_data  = 32'hBAD0_BAD0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: every output handshake pops one expected result.
    task automatic monitor();
        res_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_result actual sum=%h count=%0d required none",
                             out_sum, out_count);
                end else begin
                    e = exp_q.pop_front();
                    if (out_sum !== e.sum || out_count !== e.count ||
                        out_ovf !== e.ovf || out_trunc !== e.trunc) begin
                        fails++;
                        $display("FAIL result actual sum=%h count=%0d ovf=%b trunc=%b required sum=%h count=%0d ovf=%b trunc=%b",
                                 out_sum, out_count, out_ovf, out_trunc,
                                 e.sum, e.count, e.ovf, e.trunc);
                    end
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{{32'h0, 32'h3, 32'h2, 32'h1}, 3, 32'h6, 3'd3, 1'b0};
        vecs[1] = '{{32'h0, 32'h0, 32'h2, 32'hFFFF_FFFF}, 2,
                    SAT ? 32'hFFFF_FFFF : 32'h1, 3'd2, 1'b1};
        vecs[2] = '{{32'h0, 32'h0, 32'h0, 32'h1234}, 1, 32'h1234, 3'd1, 1'b0};
        vecs[3] = '{{32'h40, 32'h30, 32'h20, 32'h10}, 4, 32'hA0, 3'd4, 1'b0};
        vecs[4] = '{{32'h0, 32'h5, 32'h8000_0000, 32'h8000_0000}, 3,
                    SAT ? 32'hFFFF_FFFF : 32'h5, 3'd3, 1'b1};
        vecs[5] = '{{32'h0, 32'h0, 32'h0, 32'h0}, 2, 32'h0, 3'd2, 1'b0};
        vecs[6] = '{{32'h0, 32'h0, 32'h1, 32'hFFFF_FFFF}, 4,
                    SAT ? 32'hFFFF_FFFF : 32'h0, 3'd4, 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) sync();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_out_sum",   64'(out_sum),   64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        check("reset_out_ovf",   64'(out_ovf),   64'd0);
        check("reset_out_trunc", 64'(out_trunc), 64'd0);
        sync();

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{vecs[i].sum, vecs[i].cnt, vecs[i].ovf, 1'b0});
            for (int j = 0; j < vecs[i].n; j++) beat(vecs[i].d[j], j == vecs[i].n - 1);
            check("latency_out_valid", 64'(out_valid), 64'd1);
            check("latency_in_ready",  64'(in_ready),  64'd0);
            sync();
        end

        // Single beat with out_ready held: out_valid lasts exactly one cycle.
        exp_q.push_back('{32'h1234, 3'd1, 1'b0, 1'b0});
        beat(32'h1234, 1'b1);
        check("single_valid_hi", 64'(out_valid), 64'd1);
        sync();
        check("single_valid_lo", 64'(out_valid), 64'd0);
        check("single_in_ready", 64'(in_ready),  64'd1);

        // Backpressure: result held stable, offered beats not consumed.
        out_ready = 1'b0;
        exp_q.push_back('{32'hF, 3'd2, 1'b0, 1'b0});
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b1);
        in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_sum",   64'(out_sum),   64'hF);
            check("bp_out_count", 64'(out_count), 64'd2);
            check("bp_in_ready",  64'(in_ready),  64'd0);
        end
        sync();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) sync();
        check("bp_no_phantom", 64'(out_valid), 64'd0);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Truncation at MAX_BEATS, remainder forms a new burst.
        exp_q.push_back('{32'h4, 3'd4, 1'b0, 1'b1});
        exp_q.push_back('{32'h1, 3'd1, 1'b0, 1'b0});
        for (int j = 0; j < 5; j++) beat(32'h1, j == 4);
        repeat (2) sync();

        // Asynchronous reset mid-burst discards the partial sum.
        beat(32'h10, 1'b0);
        beat(32'h20, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        #1 rst = 1'b0;
        sync();
        exp_q.push_back('{32'h5, 3'd1, 1'b0, 1'b0});
        beat(32'h5, 1'b1);

        begin
            int w = 0;
            while (exp_q.size() != 0 && w < 20) begin
                sync();
                w++;
            end
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
